// File: rtl/mem_stage_if.sv
// Execute->Memory->Writeback bundle plus data-bus request/response signals for mem_stage.
// MEM_ALIGN_CHECK_EN adds the out_addr_err flag to the Writeback bundle.
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [5:0]        in_funct;
  logic [DATA_W-1:0] in_valE;
  logic [DATA_W-1:0] in_valA;
  logic [4:0]        in_dstE;
  logic [4:0]        in_dstM;
  logic [31:0]       in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_valE;
  logic [DATA_W-1:0] out_valM;
  logic [4:0]        out_dstE;
  logic [4:0]        out_dstM;
  logic [31:0]       out_pc;
`ifdef MEM_ALIGN_CHECK_EN
  logic              out_addr_err;
`endif

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic              dreq_wen;
  logic [3:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_rdata;

  modport master (
    input  in_valid, in_opcode, in_funct, in_valE, in_valA, in_dstE, in_dstM, in_pc,
    input  out_ready, dresp_addr_ok, dresp_data_ok, dresp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output out_addr_err,
`endif
    output in_ready, out_valid, out_valE, out_valM, out_dstE, out_dstM, out_pc,
    output dreq_valid, dreq_addr, dreq_wen, dreq_strobe, dreq_wdata
  );

  modport slave (
    output in_valid, in_opcode, in_funct, in_valE, in_valA, in_dstE, in_dstM, in_pc,
    output out_ready, dresp_addr_ok, dresp_data_ok, dresp_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    input  out_addr_err,
`endif
    input  in_ready, out_valid, out_valE, out_valM, out_dstE, out_dstM, out_pc,
    input  dreq_valid, dreq_addr, dreq_wen, dreq_strobe, dreq_wdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline Memory stage: passes ALU bundles through in one cycle, runs LW/SW over a
// valid/addr_ok/data_ok bus. Optional MEM_ALIGN_CHECK_EN flags misaligned word accesses.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.master bus
);
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t state, state_nxt;
  logic   fire;
  logic   is_mem;
  logic   misaligned;
  logic   done;
  logic   ld_p1;
  logic   unused_funct;

  // funct only matters to Writeback (JR etc.); the bundle passes through untouched
  assign unused_funct = ^bus.in_funct;

  assign is_mem        = (bus.in_opcode == OP_LW) || (bus.in_opcode == OP_SW);
  assign bus.in_ready  = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign fire          = bus.in_valid && bus.in_ready;
  assign bus.dreq_valid = (state == REQ);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem && (bus.in_valE[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (fire && is_mem) state_nxt = misaligned ? HOLD : REQ;
      REQ: begin
        if (bus.dresp_addr_ok) begin
          if (bus.dresp_data_ok) begin
            state_nxt = HOLD;
            done      = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.dresp_data_ok) begin
          state_nxt = HOLD;
          done      = 1'b1;
        end
      end
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writeback bundle and latched bus request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_valE    <= '0;
      bus.out_valM    <= '0;
      bus.out_dstE    <= '0;
      bus.out_dstM    <= '0;
      bus.out_pc      <= '0;
      bus.dreq_addr   <= '0;
      bus.dreq_wen    <= 1'b0;
      bus.dreq_strobe <= 4'h0;
      bus.dreq_wdata  <= '0;
      ld_p1           <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      bus.out_addr_err <= 1'b0;
`endif
    end else if (fire) begin
      bus.out_valE  <= bus.in_valE;
      bus.out_valM  <= {DATA_W{1'b0}};
      bus.out_dstE  <= bus.in_dstE;
      bus.out_dstM  <= misaligned ? 5'd0 : bus.in_dstM;
      bus.out_pc    <= bus.in_pc;
      // memory ops surface their result only once the bus access completes
      bus.out_valid <= !is_mem || misaligned;
`ifdef MEM_ALIGN_CHECK_EN
      bus.out_addr_err <= misaligned;
`endif
      if (is_mem && !misaligned) begin
        bus.dreq_addr   <= {bus.in_valE[ADDR_W-1:2], 2'b00};
        bus.dreq_wen    <= (bus.in_opcode == OP_SW);
        bus.dreq_strobe <= (bus.in_opcode == OP_SW) ? 4'hF : 4'h0;
        bus.dreq_wdata  <= bus.in_valA;
        ld_p1           <= (bus.in_opcode == OP_LW);
      end
    end else if (done) begin
      bus.out_valM  <= ld_p1 ? bus.dresp_rdata : {DATA_W{1'b0}};
      bus.out_valid <= 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ALU, LW, SW, backpressure, reset and alignment cases.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) ifc ();
  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {
    logic [31:0] valE;
    logic [31:0] valM;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] ve, input logic [31:0] vm, input logic [4:0] de,
                      input logic [4:0] dm, input logic [31:0] pc, input logic err);
    exp_t e;
    e.valE = ve; e.valM = vm; e.dstE = de; e.dstM = dm; e.pc = pc; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] ve, input logic [31:0] va,
                       input logic [4:0] de, input logic [4:0] dm, input logic [31:0] pc);
    ifc.in_valid  = 1'b1;
    ifc.in_opcode = op;
    ifc.in_funct  = 6'h00;
    ifc.in_valE   = ve;
    ifc.in_valA   = va;
    ifc.in_dstE   = de;
    ifc.in_dstM   = dm;
    ifc.in_pc     = pc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every Writeback handshake pops one expected bundle
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got bundle pc=%h, want none", ifc.out_pc);
      end else begin
        e = sb.pop_front();
        check("out_valE", ifc.out_valE, e.valE);
        check("out_valM", ifc.out_valM, e.valM);
        check("out_dstE", 32'(ifc.out_dstE), 32'(e.dstE));
        check("out_dstM", 32'(ifc.out_dstM), 32'(e.dstM));
        check("out_pc",   ifc.out_pc,   e.pc);
`ifdef MEM_ALIGN_CHECK_EN
        check("out_addr_err", 32'(ifc.out_addr_err), 32'(e.err));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid = 1'b0; ifc.in_opcode = '0; ifc.in_funct = '0; ifc.in_valE = '0;
    ifc.in_valA = '0; ifc.in_dstE = '0; ifc.in_dstM = '0; ifc.in_pc = '0;
    ifc.out_ready = 1'b1; ifc.dresp_addr_ok = 1'b0; ifc.dresp_data_ok = 1'b0;
    ifc.dresp_rdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(ifc.in_ready), 32'd1);
    check("rst_out_valid",  32'(ifc.out_valid), 32'd0);
    check("rst_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
    check("rst_out_valE",   ifc.out_valE, 32'd0);
    check("rst_out_pc",     ifc.out_pc, 32'd0);
    #1 reset = 1'b0;

    // ALU stream: 4 back-to-back ADDIU
    for (int i = 1; i <= 4; i++) begin
      step;
      drive(6'h09, 32'(i), 32'd0, 5'(i + 1), 5'd0, 32'h40 + 32'(4 * i));
      push(32'(i), 32'd0, 5'(i + 1), 5'd0, 32'h40 + 32'(4 * i), 1'b0);
      @(negedge clk);
      check("alu_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
      if (i > 1) check("alu_out_valid", 32'(ifc.out_valid), 32'd1);
    end
    step;
    ifc.in_valid = 1'b0;
    step;

    // LW: addr_ok on 2nd REQ cycle, data_ok on 3rd WAIT cycle
    drive(6'h23, 32'h1000, 32'd0, 5'd0, 5'd5, 32'h100);
    push(32'h1000, 32'hDEADBEEF, 5'd0, 5'd5, 32'h100, 1'b0);
    step;
    ifc.in_valid = 1'b0;
    ifc.dresp_data_ok = 1'b1;
    ifc.dresp_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("lw_dreq_valid0", 32'(ifc.dreq_valid), 32'd1);
    check("lw_dreq_addr0",  ifc.dreq_addr, 32'h1000);
    check("lw_dreq_wen",    32'(ifc.dreq_wen), 32'd0);
    check("lw_dreq_strobe", 32'(ifc.dreq_strobe), 32'd0);
    check("lw_in_ready0",   32'(ifc.in_ready), 32'd0);
    step;
    ifc.dresp_data_ok = 1'b0;
    ifc.dresp_addr_ok = 1'b1;
    @(negedge clk);
    check("lw_dreq_valid1", 32'(ifc.dreq_valid), 32'd1);
    check("lw_dreq_addr1",  ifc.dreq_addr, 32'h1000);
    check("lw_in_ready1",   32'(ifc.in_ready), 32'd0);
    step;
    ifc.dresp_addr_ok = 1'b0;
    @(negedge clk);
    check("lw_wait_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
    check("lw_in_ready2",       32'(ifc.in_ready), 32'd0);
    step;
    @(negedge clk);
    check("lw_in_ready3", 32'(ifc.in_ready), 32'd0);
    step;
    ifc.dresp_data_ok = 1'b1;
    ifc.dresp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("lw_in_ready4", 32'(ifc.in_ready), 32'd0);
    step;
    ifc.dresp_data_ok = 1'b0;
    ifc.dresp_rdata = '0;
    @(negedge clk);
    check("lw_out_valid",  32'(ifc.out_valid), 32'd1);
    check("lw_hold_ready", 32'(ifc.in_ready), 32'd0);
    step;

    // SW: addr_ok and data_ok together
    drive(6'h2B, 32'h2004, 32'h12345678, 5'd0, 5'd0, 32'h104);
    push(32'h2004, 32'd0, 5'd0, 5'd0, 32'h104, 1'b0);
    step;
    ifc.in_valid = 1'b0;
    ifc.dresp_addr_ok = 1'b1;
    ifc.dresp_data_ok = 1'b1;
    ifc.dresp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("sw_dreq_valid",  32'(ifc.dreq_valid), 32'd1);
    check("sw_dreq_addr",   ifc.dreq_addr, 32'h2004);
    check("sw_dreq_wen",    32'(ifc.dreq_wen), 32'd1);
    check("sw_dreq_strobe", 32'(ifc.dreq_strobe), 32'hF);
    check("sw_dreq_wdata",  ifc.dreq_wdata, 32'h12345678);
    step;
    ifc.dresp_addr_ok = 1'b0;
    ifc.dresp_data_ok = 1'b0;
    ifc.dresp_rdata = '0;
    @(negedge clk);
    check("sw_out_valid", 32'(ifc.out_valid), 32'd1);
    step;

    // Backpressure: LW completes while out_ready low for 3 cycles, ADDIU waiting
    drive(6'h23, 32'h3000, 32'd0, 5'd0, 5'd7, 32'h108);
    push(32'h3000, 32'h55AA55AA, 5'd0, 5'd7, 32'h108, 1'b0);
    step;
    drive(6'h09, 32'h77, 32'd0, 5'd9, 5'd0, 32'h10C);
    push(32'h77, 32'd0, 5'd9, 5'd0, 32'h10C, 1'b0);
    ifc.dresp_addr_ok = 1'b1;
    ifc.dresp_data_ok = 1'b1;
    ifc.dresp_rdata = 32'h55AA55AA;
    ifc.out_ready = 1'b0;
    step;
    ifc.dresp_addr_ok = 1'b0;
    ifc.dresp_data_ok = 1'b0;
    ifc.dresp_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_in_ready",  32'(ifc.in_ready), 32'd0);
      check("bp_out_valE",  ifc.out_valE, 32'h3000);
      check("bp_out_valM",  ifc.out_valM, 32'h55AA55AA);
      check("bp_out_dstM",  32'(ifc.out_dstM), 32'd7);
      step;
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("bp_hold_in_ready", 32'(ifc.in_ready), 32'd0);
    step;
    @(negedge clk);
    check("bp_idle_in_ready", 32'(ifc.in_ready), 32'd1);
    step;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("bp_alu_out_valid", 32'(ifc.out_valid), 32'd1);
    step;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW: no bus request, flagged result next cycle
    drive(6'h23, 32'h1002, 32'd0, 5'd0, 5'd6, 32'h200);
    push(32'h1002, 32'd0, 5'd0, 5'd0, 32'h200, 1'b1);
    step;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("al_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
    check("al_out_valid",  32'(ifc.out_valid), 32'd1);
    check("al_addr_err",   32'(ifc.out_addr_err), 32'd1);
    check("al_dstM",       32'(ifc.out_dstM), 32'd0);
    step;
    @(negedge clk);
    check("al_dreq_valid1", 32'(ifc.dreq_valid), 32'd0);
    step;
`endif

    // Asynchronous reset while a request is outstanding
    drive(6'h23, 32'h4000, 32'd0, 5'd0, 5'd3, 32'h300);
    step;
    ifc.in_valid = 1'b0;
    check("rst_pre_dreq_valid", 32'(ifc.dreq_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
    check("rst_mid_out_valid",  32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_post_in_ready",   32'(ifc.in_ready), 32'd1);
    check("rst_post_dreq_valid", 32'(ifc.dreq_valid), 32'd0);
    step;
    step;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline Memory stage. Sits directly downstream of the Execute stage and consumes its output bundle: opcode, funct, valE, valA, dstE, dstM, pc.
- Issues LW/SW to the data bus through a valid/addr_ok/data_ok handshake and stalls upstream while an access is outstanding.
- Presents a registered result bundle (valE, valM, dstE, dstM, pc) to Writeback.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data width; fixed at 32, others unsupported.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  Execute bundle valid
- in_ready  out  1  stage can accept bundle this cycle
- in_opcode  in  6  MIPS opcode
- in_funct  in  6  funct field
- in_valE  in  32  ALU result / effective address
- in_valA  in  32  store data (rt value)
- in_dstE  in  5  ALU-result destination register
- in_dstM  in  5  load destination register
- in_pc  in  32  instruction PC
- out_valid  out  1  Writeback bundle valid
- out_ready  in  1  Writeback accepts bundle
- out_valE  out  32  registered valE
- out_valM  out  32  load data (0 for non-loads)
- out_dstE  out  5  registered dstE
- out_dstM  out  5  registered dstM
- out_pc  out  32  registered pc
- dreq_valid  out  1  data request valid
- dreq_addr  out  32  word address (valE with [1:0] forced to 0)
- dreq_wen  out  1  1 = store
- dreq_strobe  out  4  byte enables: 4'hF on SW, 0 on LW
- dreq_wdata  out  32  store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  access complete
- dresp_rdata  in  32  load data

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs 0, state = IDLE, in_ready = 1.
- States:
  - IDLE: no access in flight.
  - REQ: dreq_valid high, waiting for addr_ok.
  - WAIT: waiting for data_ok.
  - HOLD: result held for Writeback.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Non-memory op accepted (fire = in_valid && in_ready, opcode not LW/SW):
  - Output registers load on the next edge; out_valid = 1; out_valM = 0.
  - State stays IDLE. Latency is 1 cycle with full throughput.
- LW/SW accepted:
  - Latch the bundle; out_valid drops to 0 (after out_ready consumed the previous bundle); state goes to REQ.
  - dreq_* are driven from latched registers only, never combinationally from in_*.
- REQ:
  - dreq_valid = 1, held with stable address/data until dresp_addr_ok.
  - On addr_ok the next state is WAIT.
  - If addr_ok and data_ok arrive in the same cycle, go straight to HOLD and capture rdata.
- WAIT:
  - dreq_valid = 0.
  - On data_ok: capture dresp_rdata into out_valM (LW) or 0 (SW); out_valid = 1; state goes to HOLD.
- HOLD:
  - out_valid = 1 until out_ready; then state goes to IDLE.
  - in_ready is 0 throughout HOLD; a new instruction may enter the cycle after the handshake.
- data_ok outside WAIT (or REQ with addr_ok) is ignored.
- Writeback backpressure: out_* hold stable while out_valid && !out_ready.
- JR and other no-writeback ops: passed through unchanged; dst fields decide whether Writeback writes.
- reset mid-access: returns to IDLE immediately and drops dreq_valid. The bus slave must tolerate the abandoned request.
- Only word accesses exist. dreq_addr[1:0] is always 0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port out_addr_err (1 bit, reset 0).
  - An LW/SW with in_valE[1:0] != 0 issues no bus request and goes IDLE -> HOLD with out_addr_err = 1, out_valM = 0, out_dstM = 0.
  - out_addr_err is 0 for all other bundles.
- Undefined: port absent; low address bits are silently dropped and the access proceeds.

Test Plan:
- Reset: assert reset asynchronously mid-REQ (dreq_valid = 1) -> dreq_valid, out_valid = 0 in the same cycle; in_ready = 1 after release.
- ALU stream: 4 back-to-back ADDIU bundles with valE = 1..4, out_ready = 1 -> out_valE = 1,2,3,4 on consecutive cycles; out_valM = 0; no dreq_valid.
- LW with valE = 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with rdata = 0xDEADBEEF:
  - dreq_addr = 0x1000, wen = 0, strobe = 0, held for 2 cycles;
  - out_valM = 0xDEADBEEF, out_dstM preserved;
  - in_ready = 0 throughout.
- SW with valE = 0x2004, valA = 0x12345678, addr_ok and data_ok in the same cycle -> dreq_wdata = 0x12345678, strobe = 4'hF, wen = 1; next cycle out_valid = 1 with out_valM = 0.
- Backpressure: LW completes while out_ready = 0 for 3 cycles -> out_* stable, in_ready = 0; a pending ADDIU enters the cycle after out_ready goes high.
- With MEM_ALIGN_CHECK_EN: LW with valE = 0x1002 -> dreq_valid never rises; out_addr_err = 1, out_dstM = 0 on the next cycle.
